regfile_maint_controller: RTL

Maintenance sequencer that sits between the core writeback path and the 32x32 register file. It owns the single write port and the debug read port. In normal operation it passes core writes straight through. On command it either clears x1..x31 to zero through the write port, or walks the debug read port over a register range and streams the values out on a valid/ready interface for the debug/UART unit.

---
 rtl/regfile_maint_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/regfile_maint_controller.sv
// Register-file maintenance sequencer: core write pass-through,
// bulk clear of x1..x31, and debug dump of a register range.
module regfile_maint_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_clear,
    input  logic             start_dump,
    input  logic [4:0]       first_reg,
    input  logic [4:0]       last_reg,
    input  logic             core_we,
    input  logic [4:0]       core_rd,
    input  logic [WIDTH-1:0] core_data,
    output logic             core_stall,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [WIDTH-1:0] rf_data,
    output logic [4:0]       rf_dbg_sel,
    input  logic [WIDTH-1:0] rf_dbg_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [4:0]       dump_index,
    output logic [WIDTH-1:0] dump_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        DUMP_SEL,
        DUMP_OUT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [4:0]       idx;
    logic [4:0]       idx_nx;
    logic [4:0]       last;
    logic [4:0]       last_nx;
    logic             dump_valid_nx;
    logic [4:0]       dump_index_nx;
    logic [WIDTH-1:0] dump_data_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            last       <= '0;
            dump_valid <= 1'b0;
            dump_index <= '0;
            dump_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            last       <= last_nx;
            dump_valid <= dump_valid_nx;
            dump_index <= dump_index_nx;
            dump_data  <= dump_data_nx;
            busy       <= (state_nx != IDLE);
            done       <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        last_nx       = last;
        dump_valid_nx = dump_valid;
        dump_index_nx = dump_index;
        dump_data_nx  = dump_data;
        rf_we         = core_we;
        rf_rd         = core_rd;
        rf_data       = core_data;
        core_stall    = 1'b0;
        rf_dbg_sel    = '0;

        unique case (state)
            IDLE: begin
                if (start_clear) begin
                    state_nx = CLEAR;
                    idx_nx   = 5'd1;
                end else if (start_dump) begin
                    state_nx = DUMP_SEL;
                    idx_nx   = first_reg;
                    last_nx  = last_reg;
                end
            end
            CLEAR: begin
                // The write port belongs to the clear sweep; the core waits.
                rf_we      = 1'b1;
                rf_rd      = idx;
                rf_data    = '0;
                core_stall = core_we;
                idx_nx     = idx + 5'd1;
                if (idx == 5'd31) begin
                    state_nx = DONE;
                end
            end
            DUMP_SEL: begin
                rf_dbg_sel    = idx;
                dump_data_nx  = rf_dbg_data;
                dump_index_nx = idx;
                dump_valid_nx = 1'b1;
                state_nx      = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (dump_valid && dump_ready) begin
                    dump_valid_nx = 1'b0;
                    if (idx == last) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx   = idx + 5'd1;
                        state_nx = DUMP_SEL;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
